control_unit_gen: RTL and testbench
===================================

Name: control_unit_gen

Overview:
- Parametrised next-generation control unit for the datapath: one-hot register strobes, ALU control and external-load strobe.
- Adds a run/ready instruction handshake with an internal instruction register, so `instr` need only be valid in the accept cycle.
- Adds an external-data valid handshake for load, illegal-instruction detection and 2-bit ALU mode.

Parameters:
NUM_REGS, 4, number of general registers; width of rin/rout one-hot vectors
REG_SEL_BITS, 4, width of each register-select field in the instruction
OPCODE_BITS, 3, opcode field width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
run  in  1  instruction-valid strobe; sampled only while ready=1
instr  in  OPCODE_BITS+2*REG_SEL_BITS  {opcode, rx field, ry field}, MSB first
ext_valid  in  1  external data valid for load
ready  out  1  unit idle, will accept run
rin  out  NUM_REGS  one-hot register write enable
rout  out  NUM_REGS  one-hot register bus drive
ext_load  out  1  external data drives bus
alu_a_in  out  1  ALU A-latch enable
alu_g_in  out  1  ALU G-latch enable
alu_g_out  out  1  G drives bus
alu_mode  out  2  00 add, 01 sub, 10 and, 11 xor
done  out  1  one-cycle pulse in final cycle of every instruction
illegal  out  1  one-cycle pulse on rejected instruction

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset: state=IDLE, IR=0. All outputs are 0 except ready=1. Reset dominates run, ext_valid and any in-flight instruction; the instruction is aborted with no done.
- Outputs are decoded combinationally from the registered state and IR only; no path from instr to outputs.
- Register field value k, 1<=k<=NUM_REGS, selects one-hot bit k-1. Value 0 or k>NUM_REGS is invalid.
- Opcodes: 000 load (rx), 001 mov (rx<-ry), 010 add, 011 sub (rx<-rx op ry). 100 and / 101 xor only with the optional feature. All other opcodes are illegal.
- Accept: in IDLE with run=1, IR<=instr and the state advances at that edge. run is ignored while ready=0.
- Illegal instruction: unknown opcode, invalid rx, or invalid ry (ry is checked only for mov/ALU ops). The unit goes to ERR for one cycle: illegal=1, done=1, all strobes 0, then IDLE.
- States and per-cycle outputs (unlisted outputs are 0):
  - IDLE: ready=1.
  - LOAD: waits while ext_valid=0 with all outputs 0. In the first cycle with ext_valid=1: rin=rx, ext_load=1, done=1, then IDLE. If ext_valid is already 1 on entry, load completes in 1 cycle.
  - MOVE: rin=rx, rout=ry, done=1, then IDLE. rx==ry is legal (same bit in rin and rout).
  - ALU1: rout=rx, alu_a_in=1.
  - ALU2: rout=ry, alu_g_in=1, alu_mode per opcode.
  - ALU3: rin=rx, alu_g_out=1, done=1, then IDLE.
- alu_mode=00 in every state except ALU2.
- Latency from accept edge: mov 1 cycle, ALU ops 3 cycles, load 1+wait cycles.
- Next accept is possible in the cycle after done, because ready=1 in IDLE.
- Changes on instr after accept have no effect.

Optional Feature:
- Macro CTRL_LOGIC_OPS_EN.
- Defined: opcodes 100 (and, alu_mode=10) and 101 (xor, alu_mode=11) run the ALU1-ALU3 sequence.
- Undefined: 100/101 are illegal, and alu_mode only takes 00/01.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants
  - state enum (IDLE, LOAD, MOVE, ALU1, ALU2, ALU3, ERR)
  - alu_mode constants
  - default widths
- Sub-module reg_sel_decoder (field -> one-hot NUM_REGS + valid), instantiated twice for rx and ry.

Test Plan:
- reset mid-ALU2 of add R1,R3 -> next cycle all outputs 0, ready=1, no done.
- run with instr=010_0001_0011 (add R1,R3) -> cycle+1 rout=0001, alu_a_in. Cycle+2 rout=0100, alu_g_in, mode 00. Cycle+3 rin=0001, alu_g_out, done. Cycle+4 ready=1.
- load R4 (000_0100_0000) with ext_valid low 3 cycles then high -> 3 idle cycles, then rin=1000, ext_load=1, done=1 for one cycle.
- mov R2,R2 (001_0010_0010) -> one cycle rin=0010, rout=0010, done. Also: run held high during it is ignored, and instr changed mid-op has no effect.
- illegal cases 110_0001_0001, add R5 (010_0101_0001) and mov R1,R0 -> illegal=1, done=1, rin=rout=0, next cycle ready=1.
- opcode 101_0001_0010 -> with CTRL_LOGIC_OPS_EN: alu_mode=11 in ALU2. Without it: illegal pulse.

Source files
------------

// File: rtl/control_unit_gen_pkg.sv
// Shared types and constants for control_unit_gen: opcodes, FSM states, ALU modes.
// CTRL_LOGIC_OPS_EN adds the AND/XOR opcodes and their ALU modes.
package ctrl_pkg;

  localparam int DEF_NUM_REGS     = 4;
  localparam int DEF_REG_SEL_BITS = 4;
  localparam int DEF_OPCODE_BITS  = 3;

  localparam int OP_LOAD = 0;
  localparam int OP_MOV  = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_SUB  = 3;
`ifdef CTRL_LOGIC_OPS_EN
  localparam int OP_AND  = 4;
  localparam int OP_XOR  = 5;
`endif

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
`ifdef CTRL_LOGIC_OPS_EN
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOVE,
    ALU1,
    ALU2,
    ALU3,
    ERR
  } state_t;

endpackage

// File: rtl/control_unit_gen_reg_sel_decoder.sv
// Register-select field to one-hot decoder; field value k (1..NUM_REGS) selects bit k-1.
module reg_sel_decoder #(
  parameter int NUM_REGS = 4,
  parameter int SEL_BITS = 4
) (
  input  logic [SEL_BITS-1:0] sel,
  output logic [NUM_REGS-1:0] one_hot,
  output logic                valid
);

  // NOTE: every output gets a default before the loop so no path can infer a latch.
  always_comb begin
    one_hot = '0;
    valid   = 1'b0;
    for (int k = 1; k <= NUM_REGS; k++) begin
      if (sel == SEL_BITS'(k)) begin
        one_hot[k-1] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_unit_gen.sv
// Control unit with run/ready handshake, decoded instruction register and illegal-op detection.
// Define CTRL_LOGIC_OPS_EN to enable the AND/XOR opcodes.
module control_unit_gen
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int REG_SEL_BITS = DEF_REG_SEL_BITS,
  parameter int OPCODE_BITS  = DEF_OPCODE_BITS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
  input  logic [OPCODE_BITS+2*REG_SEL_BITS-1:0] instr,
  input  logic                                ext_valid,
  output logic                                ready,
  output logic [NUM_REGS-1:0]                 rin,
  output logic [NUM_REGS-1:0]                 rout,
  output logic                                ext_load,
  output logic                                alu_a_in,
  output logic                                alu_g_in,
  output logic                                alu_g_out,
  output logic [1:0]                          alu_mode,
  output logic                                done,
  output logic                                illegal
);

  localparam int IW = OPCODE_BITS + 2*REG_SEL_BITS;

  state_t state, state_nxt, accept_state;

  logic [OPCODE_BITS-1:0]  in_op;
  logic [REG_SEL_BITS-1:0] in_rx, in_ry;
  logic [NUM_REGS-1:0]     rx_oh, ry_oh;
  logic                    rx_valid, ry_valid;

  // Instruction register kept in decoded form: opcode plus one-hot rx/ry.
  logic [OPCODE_BITS-1:0]  ir_op;
  logic [NUM_REGS-1:0]     ir_rx, ir_ry;

  assign in_op = instr[IW-1 -: OPCODE_BITS];
  assign in_rx = instr[2*REG_SEL_BITS-1 -: REG_SEL_BITS];
  assign in_ry = instr[REG_SEL_BITS-1:0];

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_BITS(REG_SEL_BITS)) u_rx_dec (
    .sel     (in_rx),
    .one_hot (rx_oh),
    .valid   (rx_valid)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_BITS(REG_SEL_BITS)) u_ry_dec (
    .sel     (in_ry),
    .one_hot (ry_oh),
    .valid   (ry_valid)
  );

  // Legality is settled at accept, so a bad instruction never reaches a datapath state.
  always_comb begin
    accept_state = ERR;
    case (in_op)
      OPCODE_BITS'(OP_LOAD): if (rx_valid)             accept_state = LOAD;
      OPCODE_BITS'(OP_MOV):  if (rx_valid && ry_valid) accept_state = MOVE;
      OPCODE_BITS'(OP_ADD),
`ifdef CTRL_LOGIC_OPS_EN
      OPCODE_BITS'(OP_AND),
      OPCODE_BITS'(OP_XOR),
`endif
      OPCODE_BITS'(OP_SUB):  if (rx_valid && ry_valid) accept_state = ALU1;
      default:               accept_state = ERR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_op <= '0;
      ir_rx <= '0;
      ir_ry <= '0;
    end else if (state == IDLE && run) begin
      ir_op <= in_op;
      ir_rx <= rx_oh;
      ir_ry <= ry_oh;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:            if (run) state_nxt = accept_state;
      LOAD:            if (ext_valid) state_nxt = IDLE;
      ALU1:            state_nxt = ALU2;
      ALU2:            state_nxt = ALU3;
      MOVE, ALU3, ERR: state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    rin       = '0;
    rout      = '0;
    ext_load  = 1'b0;
    alu_a_in  = 1'b0;
    alu_g_in  = 1'b0;
    alu_g_out = 1'b0;
    alu_mode  = ALU_ADD;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      LOAD: begin
        if (ext_valid) begin
          rin      = ir_rx;
          ext_load = 1'b1;
          done     = 1'b1;
        end
      end
      MOVE: begin
        rin  = ir_rx;
        rout = ir_ry;
        done = 1'b1;
      end
      ALU1: begin
        rout     = ir_rx;
        alu_a_in = 1'b1;
      end
      ALU2: begin
        rout     = ir_ry;
        alu_g_in = 1'b1;
        case (ir_op)
          OPCODE_BITS'(OP_SUB): alu_mode = ALU_SUB;
`ifdef CTRL_LOGIC_OPS_EN
          OPCODE_BITS'(OP_AND): alu_mode = ALU_AND;
          OPCODE_BITS'(OP_XOR): alu_mode = ALU_XOR;
`endif
          default:              alu_mode = ALU_ADD;
        endcase
      end
      ALU3: begin
        rin       = ir_rx;
        alu_g_out = 1'b1;
        done      = 1'b1;
      end
      ERR: begin
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_gen.sv
// Directed bench for control_unit_gen: outputs packed into one vector and compared per cycle.
module tb_control_unit_gen;

  logic        clk = 1'b0;
  logic        reset, run, ext_valid;
  logic [10:0] instr;
  logic        ready, ext_load, alu_a_in, alu_g_in, alu_g_out, done, illegal;
  logic [3:0]  rin, rout;
  logic [1:0]  alu_mode;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  control_unit_gen dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .instr     (instr),
    .ext_valid (ext_valid),
    .ready     (ready),
    .rin       (rin),
    .rout      (rout),
    .ext_load  (ext_load),
    .alu_a_in  (alu_a_in),
    .alu_g_in  (alu_g_in),
    .alu_g_out (alu_g_out),
    .alu_mode  (alu_mode),
    .done      (done),
    .illegal   (illegal)
  );

  // {ready, rin, rout, ext_load, a_in, g_in, g_out, mode, done, illegal}
  logic [16:0] obs;
  assign obs = {ready, rin, rout, ext_load, alu_a_in, alu_g_in, alu_g_out, alu_mode, done, illegal};

  function automatic logic [16:0] ev(input logic rdy, input logic [3:0] ri, input logic [3:0] ro,
                                     input logic el, input logic ai, input logic gi, input logic go,
                                     input logic [1:0] m, input logic d, input logic il);
    return {rdy, ri, ro, el, ai, gi, go, m, d, il};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, want);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [16:0] IDLE_O = 17'h10000;
  localparam logic [16:0] ZERO_O = 17'h00000;

  initial begin
    reset = 1'b1; run = 1'b0; ext_valid = 1'b0; instr = '0;
    tick; tick;
    check("reset", obs, IDLE_O);
    reset = 1'b0;

    // add R1,R3 with run held high and instr changed after accept
    run = 1'b1; instr = 11'b010_0001_0011;
    tick;
    instr = 11'b001_0010_0100;
    check("add_alu1", obs, ev(0, 4'b0000, 4'b0001, 0, 1, 0, 0, 2'b00, 0, 0));
    tick;
    check("add_alu2", obs, ev(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 2'b00, 0, 0));
    run = 1'b0;
    tick;
    check("add_alu3", obs, ev(0, 4'b0001, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 0));
    tick;
    check("add_idle", obs, IDLE_O);

    // sub R2,R4
    run = 1'b1; instr = 11'b011_0010_0100;
    tick; run = 1'b0;
    check("sub_alu1", obs, ev(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 2'b00, 0, 0));
    tick;
    check("sub_alu2", obs, ev(0, 4'b0000, 4'b1000, 0, 0, 1, 0, 2'b01, 0, 0));
    tick;
    check("sub_alu3", obs, ev(0, 4'b0010, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 0));
    tick;

    // load R4 with three wait cycles
    run = 1'b1; instr = 11'b000_0100_0000;
    tick; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("load_wait", obs, ZERO_O);
      tick;
    end
    check("load_wait3", obs, ZERO_O);
    ext_valid = 1'b1; #1;
    check("load_done", obs, ev(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 2'b00, 1, 0));
    tick; ext_valid = 1'b0; #1;
    check("load_idle", obs, IDLE_O);

    // load R1 with ext_valid already high
    run = 1'b1; ext_valid = 1'b1; instr = 11'b000_0001_0000;
    tick; run = 1'b0;
    check("load_fast", obs, ev(0, 4'b0001, 4'b0000, 1, 0, 0, 0, 2'b00, 1, 0));
    tick; ext_valid = 1'b0; #1;
    check("load_fast_idle", obs, IDLE_O);

    // mov R2,R2 with run held and instr changed mid-op
    run = 1'b1; instr = 11'b001_0010_0010;
    tick;
    instr = 11'b010_0001_0011;
    check("mov_same", obs, ev(0, 4'b0010, 4'b0010, 0, 0, 0, 0, 2'b00, 1, 0));
    run = 1'b0;
    tick;
    check("mov_idle", obs, IDLE_O);

    // illegal instructions
    run = 1'b1; instr = 11'b110_0001_0001;
    tick; run = 1'b0;
    check("ill_opcode", obs, ev(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 1));
    tick;
    check("ill_opcode_idle", obs, IDLE_O);
    run = 1'b1; instr = 11'b010_0101_0001;
    tick; run = 1'b0;
    check("ill_rx5", obs, ev(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 1));
    tick;
    check("ill_rx5_idle", obs, IDLE_O);
    run = 1'b1; instr = 11'b001_0001_0000;
    tick; run = 1'b0;
    check("ill_ry0", obs, ev(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 1));
    tick;
    check("ill_ry0_idle", obs, IDLE_O);

    // xor R1,R2 / and R3,R1
    run = 1'b1; instr = 11'b101_0001_0010;
    tick; run = 1'b0;
`ifdef CTRL_LOGIC_OPS_EN
    check("xor_alu1", obs, ev(0, 4'b0000, 4'b0001, 0, 1, 0, 0, 2'b00, 0, 0));
    tick;
    check("xor_alu2", obs, ev(0, 4'b0000, 4'b0010, 0, 0, 1, 0, 2'b11, 0, 0));
    tick;
    check("xor_alu3", obs, ev(0, 4'b0001, 4'b0000, 0, 0, 0, 1, 2'b00, 1, 0));
    tick;
    run = 1'b1; instr = 11'b100_0011_0001;
    tick; run = 1'b0; tick;
    check("and_alu2", obs, ev(0, 4'b0000, 4'b0001, 0, 0, 1, 0, 2'b10, 0, 0));
    tick; tick;
`else
    check("xor_illegal", obs, ev(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 1));
    tick;
    run = 1'b1; instr = 11'b100_0011_0001;
    tick; run = 1'b0;
    check("and_illegal", obs, ev(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'b00, 1, 1));
    tick;
`endif
    check("logic_idle", obs, IDLE_O);

    // reset in ALU2 of add R1,R3 aborts with no done
    run = 1'b1; instr = 11'b010_0001_0011;
    tick; run = 1'b0;
    tick;
    check("rst_pre_alu2", obs, ev(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 2'b00, 0, 0));
    reset = 1'b1;
    tick;
    check("rst_abort", obs, IDLE_O);
    reset = 1'b0;
    tick;
    check("rst_no_done", obs, IDLE_O);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
